// File: rtl/mult_share_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter: FSM states,
// the {valid, id} tag carried beside each product, and the round-robin pick.
package mult_share_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOCK  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int TAG_IDW   = 8;
  localparam int RR_MAXREQ = 32;

  typedef struct packed {
    logic               valid;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  // Bit positions of the scaled result {p[2W-1], p[2W-4:W-2]}
  function automatic int sc_msb(input int w);
    return 2 * w - 1;
  endfunction

  function automatic int sc_hi(input int w);
    return 2 * w - 4;
  endfunction

  function automatic int sc_lo(input int w);
    return w - 2;
  endfunction

  // First valid index searching from ptr+1 modulo nreq; -1 when none is valid.
  function automatic int rr_pick(input logic [RR_MAXREQ-1:0] valid,
                                 input int nreq, input int ptr);
    int sel;
    int idx;
    sel = -1;
    for (int k = nreq; k >= 1; k--) begin
      idx = (ptr + k) % nreq;
      if (valid[idx[4:0]]) sel = idx;
    end
    return sel;
  endfunction

endpackage

// File: rtl/multfix.sv
// Pipelined signed fixed-point multiplier: full 2*WIDTH product, CYCLES edges of latency.
module multfix #(
  parameter int WIDTH  = 35,
  parameter int CYCLES = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [WIDTH-1:0]   a_i,
  input  logic signed [WIDTH-1:0]   b_i,
  output logic signed [2*WIDTH-1:0] p_o
);
  logic signed [2*WIDTH-1:0] a_ext;
  logic signed [2*WIDTH-1:0] b_ext;
  logic signed [2*WIDTH-1:0] prod_p [CYCLES];
  logic                      unused_rst;

  assign a_ext      = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign b_ext      = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign unused_rst = rst;

  // stage 0 captures the product, later stages only delay it
  always_ff @(posedge clk) begin
    prod_p[0] <= a_ext * b_ext;
    for (int i = 1; i < CYCLES; i++) prod_p[i] <= prod_p[i-1];
  end

  assign p_o = prod_p[CYCLES-1];

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin share of one pipelined signed multiplier among NREQ requesters.
// Optional burst lock via req_lock is compiled only with MULT_SHARE_ARB_LOCK_EN.
module mult_share_arb
  import mult_share_pkg::*;
#(
  parameter int WIDTH  = 35,
  parameter int CYCLES = 6,
  parameter int NREQ   = 4,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_lock,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sc,
  output logic [WIDTH-1:0]      rsp_unsc,
  output logic                  busy
);
  localparam int SC_MSB = sc_msb(WIDTH);
  localparam int SC_HI  = sc_hi(WIDTH);
  localparam int SC_LO  = sc_lo(WIDTH);

  state_e                    state_q;
  logic [IDW-1:0]            ptr_q;
`ifdef MULT_SHARE_ARB_LOCK_EN
  logic [IDW-1:0]            owner_q;
`endif
  tag_t                      tag_q [CYCLES];
  tag_t                      tag_d;

  int                        pick;
  logic                      block;
  logic                      hs;
  logic [IDW-1:0]            win;
  logic [NREQ-1:0]           grant;
  logic signed [WIDTH-1:0]   a_mux;
  logic signed [WIDTH-1:0]   b_mux;
  logic signed [2*WIDTH-1:0] prod;
  logic                      unused_bits;

  always_comb begin
    block = drain_req | (state_q == ST_DRAIN);
    pick  = rr_pick(RR_MAXREQ'(req_valid), NREQ, int'(ptr_q));
`ifdef MULT_SHARE_ARB_LOCK_EN
    if (state_q == ST_LOCK) pick = req_valid[owner_q] ? int'(owner_q) : -1;
`endif
    grant = '0;
    for (int i = 0; i < NREQ; i++) grant[i] = !block && (pick == i);
    hs  = |grant;
    win = (pick >= 0) ? IDW'(pick) : '0;
  end

  assign req_ready = grant;

  always_comb begin
    a_mux = '0;
    b_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        a_mux = req_a[i*WIDTH +: WIDTH];
        b_mux = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      ptr_q   <= IDW'(NREQ - 1);
`ifdef MULT_SHARE_ARB_LOCK_EN
      owner_q <= '0;
`endif
    end else begin
      if (hs) ptr_q <= win;
      case (state_q)
        ST_RUN: begin
          if (drain_req) state_q <= ST_DRAIN;
`ifdef MULT_SHARE_ARB_LOCK_EN
          else if (hs && req_lock[win]) begin
            state_q <= ST_LOCK;
            owner_q <= win;
          end
`endif
        end
`ifdef MULT_SHARE_ARB_LOCK_EN
        ST_LOCK: begin
          if (drain_req) state_q <= ST_DRAIN;
          else if (!req_lock[owner_q]) begin
            state_q <= ST_RUN;
            ptr_q   <= owner_q;
          end
        end
`endif
        ST_DRAIN: if (!drain_req) state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  assign tag_d.valid = hs;
  assign tag_d.id    = TAG_IDW'(win);

  // tag pipe stays aligned with the product pipe inside multfix
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CYCLES; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < CYCLES; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < CYCLES; i++) busy = busy | tag_q[i].valid;
  end

  multfix #(
    .WIDTH (WIDTH),
    .CYCLES(CYCLES)
  ) u_multfix (
    .clk(clk),
    .rst(1'b0),
    .a_i(a_mux),
    .b_i(b_mux),
    .p_o(prod)
  );

  assign rsp_valid  = tag_q[CYCLES-1].valid;
  assign rsp_id     = IDW'(tag_q[CYCLES-1].id);
  assign rsp_sc     = {prod[SC_MSB], prod[SC_HI:SC_LO]};
  assign rsp_unsc   = prod[WIDTH-1:0];
  assign drain_done = (state_q == ST_DRAIN) && !busy;

`ifdef MULT_SHARE_ARB_LOCK_EN
  assign unused_bits = ^{prod, tag_q[CYCLES-1].id};
`else
  assign unused_bits = ^{prod, tag_q[CYCLES-1].id, req_lock};
`endif

endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin scheduler that shares one pipelined signed fixed-point multiplier among `NREQ` requesters. It accepts one operand pair per cycle from the winning requester and feeds it to the multiplier. An ID tag travels down a shift pipeline matched to the multiplier latency, and each result is returned with the ID of the requester that issued it. The block sits between the convolution PEs and the shared `multfix` datapath, and provides a drain handshake for reconfiguration.

## Interface
- `WIDTH`, 35, operand and result width (signed, two's complement)
- `CYCLES`, 6, multiplier latency in clock edges (≥1)
- `NREQ`, 4, number of requesters (≥2)
- `IDW`, `$clog2(NREQ)`, requester-ID width (derived)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in NREQ: requester i has an operand pair
- `req_ready` out NREQ: grant; handshake on `req_valid[i] & req_ready[i]`
- `req_a` in NREQ*WIDTH: operand a, slice i = [i*WIDTH +: WIDTH]
- `req_b` in NREQ*WIDTH: operand b, same slicing
- `req_lock` in NREQ: burst-lock request (see Configuration)
- `drain_req` in 1: level; stop issuing and empty the pipe
- `drain_done` out 1: pipe empty while draining
- `rsp_valid` out 1: result present this cycle
- `rsp_id` out IDW: issuing requester
- `rsp_sc` out WIDTH: scaled product {p[2W-1], p[2W-4:W-2]}
- `rsp_unsc` out WIDTH: unscaled product p[W-1:0]
- `busy` out 1: any tag in flight

## Operation
- States: RUN, LOCK, DRAIN.
- RUN grant rules:
  - At most one `req_ready` bit is high per cycle.
  - The winner is the first valid requester searching from `ptr+1` modulo NREQ.
  - `req_ready` depends combinationally on `req_valid`; requesters must not make valid depend on ready.
  - `ptr` updates to the winner only on a handshake.
- Operands of the winner are muxed combinationally into the multiplier. With no handshake, the tag stage 0 valid bit is 0 and operands are don't-care.
- Tag pipe is CYCLES stages of {valid, id}, aligned with the product pipe. `rsp_valid`/`rsp_id` come from the last stage.
- Products are full 2*WIDTH signed; truncation happens only on the outputs as listed, with no saturation or rounding.
- No response backpressure: requesters must always accept `rsp_valid` addressed to their ID.
- DRAIN:
  - Entered from RUN or LOCK on the edge where `drain_req` is sampled high.
  - All `req_ready` are forced low combinationally whenever `drain_req`=1 or state=DRAIN.
  - `drain_done` = (state==DRAIN) & !busy.
  - Returns to RUN on the edge where `drain_req` is sampled low. `ptr` is preserved.
- Simultaneous handshake and `drain_req` is impossible, since the grant is suppressed.
- Reset, including mid-operation:
  - State → RUN, `ptr` → NREQ-1 (requester 0 has first priority), tag pipe cleared.
  - `rsp_valid`, `drain_done`, `busy` go to 0 immediately.
  - In-flight products are discarded.
  - The product pipe is not reset, so `rsp_sc`/`rsp_unsc` are undefined until the first `rsp_valid`.

## Timing
- Handshake sampled at edge E gives `rsp_valid`=1 in the cycle following edge E+CYCLES-1 (latency CYCLES edges, counted from E).
- Throughput is one issue per cycle and one result per cycle.
- Fairness: a continuously valid requester is granted within NREQ handshakes (RUN state only).
- `drain_done` rises at most CYCLES cycles after DRAIN entry.

## Configuration
- `MULT_SHARE_ARB_LOCK_EN` defined:
  - A handshake with `req_lock[i]`=1 in RUN moves the block to LOCK with owner=i.
  - In LOCK only the owner may be granted.
  - LOCK returns to RUN on the edge where the owner's `req_lock` is sampled low, with `ptr`=owner.
  - `drain_req` overrides LOCK.
- Undefined:
  - `req_lock` is ignored, LOCK is unreachable and its logic is not compiled.
  - The port remains for a stable footprint.

## Structure
- Package `mult_share_pkg`: state enum (RUN/LOCK/DRAIN), tag struct {valid, id}, and the scaled-slice bit-position constants as functions of WIDTH.
- One sub-module: `multfix` (WIDTH, CYCLES) instantiated as the datapath. `rst` is tied off since it is unused by the datapath.
- The round-robin pick is a function in the package, not a separate module.

## Test plan
- Single request: NREQ=4, CYCLES=6, req0 a=3, b=-5 → `rsp_valid` 6 edges later, `rsp_id`=0, `rsp_unsc`=-15.
- All four valid every cycle for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses return in the same order with 1-cycle spacing.
- Drain: `drain_req` raised with 3 results in flight → `req_ready` low the same cycle, `drain_done` rises after the last `rsp_valid`. Dropping `drain_req` resumes with the next RR requester.
- `rst_n` asserted mid-burst → `rsp_valid`/`busy` low asynchronously; after release, requester 0 is granted first and no stale responses appear.
- Scaled output: a=b=2^(WIDTH-2)-1 (large positive) → `rsp_sc` equals {p[2W-1], p[2W-4:W-2]} against the reference model.
- LOCK_EN: req2 locks while 0,1,3 are valid → only 2 granted until `req_lock[2]` drops, then grant passes to 3.
